// File: rtl/toy_mext_iq_pkg.sv
// Shared widths, depth constants and entry layout for the M-extension issue queue.
package toy_mext_iq_pkg;

   localparam int REG_WIDTH        = 64;
   localparam int INST_WIDTH       = 32;
   localparam int INST_IDX_WIDTH   = 8;
   localparam int PHY_REG_ID_WIDTH = 7;
   localparam int ADDR_WIDTH       = 32;

   localparam int MEXT_IQ_DEPTH    = 4;
   localparam int MEXT_IQ_WB_PORTS = 2;

   typedef struct packed {
      logic [PHY_REG_ID_WIDTH-1:0] idx;
      logic                        rdy;
      logic [REG_WIDTH-1:0]        val;
   } mext_iq_opnd_t;

   typedef struct packed {
      logic [INST_WIDTH-1:0]       inst_pld;
      logic [INST_IDX_WIDTH-1:0]   inst_idx;
      logic [PHY_REG_ID_WIDTH-1:0] rd_idx;
      logic                        rd_en;
      logic                        c_ext;
      logic [4:0]                  arch_reg_index;
      logic [ADDR_WIDTH-1:0]       pc;
      mext_iq_opnd_t               rs1;
      mext_iq_opnd_t               rs2;
   } mext_iq_entry_pkg;

endpackage

// File: rtl/toy_mext_iq_wakeup.sv
// One operand slot: compares its tag against every writeback port and
// produces the next ready/value pair, lowest-numbered port taking priority.
module toy_mext_iq_wakeup
   import toy_mext_iq_pkg::*;
#(
   parameter int WB_PORTS = MEXT_IQ_WB_PORTS
) (
   input  logic                                 cur_rdy,
   input  logic [PHY_REG_ID_WIDTH-1:0]          cur_idx,
   input  logic [REG_WIDTH-1:0]                 cur_val,
   input  logic [WB_PORTS-1:0]                  wb_vld,
   input  logic [WB_PORTS*PHY_REG_ID_WIDTH-1:0] wb_idx,
   input  logic [WB_PORTS*REG_WIDTH-1:0]        wb_val,
   output logic                                 nxt_rdy,
   output logic [REG_WIDTH-1:0]                 nxt_val
);

   // Scanning from the top port down lets the lowest matching port overwrite last.
   always_comb begin
      nxt_rdy = cur_rdy;
      nxt_val = cur_val;
      if (!cur_rdy) begin
         for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_vld[p] && (wb_idx[p*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] == cur_idx)) begin
               nxt_rdy = 1'b1;
               nxt_val = wb_val[p*REG_WIDTH +: REG_WIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/toy_mext_iq.sv
// In-order issue queue feeding the M-extension execute unit; operands are
// captured from writeback broadcasts and the oldest entry issues once complete.
module toy_mext_iq
   import toy_mext_iq_pkg::*;
#(
   parameter int DEPTH    = MEXT_IQ_DEPTH,
   parameter int WB_PORTS = MEXT_IQ_WB_PORTS
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 enq_vld,
   output logic                                 enq_rdy,
   input  logic [INST_WIDTH-1:0]                enq_inst_pld,
   input  logic [INST_IDX_WIDTH-1:0]            enq_inst_idx,
   input  logic [PHY_REG_ID_WIDTH-1:0]          enq_rd_idx,
   input  logic                                 enq_rd_en,
   input  logic                                 enq_c_ext,
   input  logic [4:0]                           enq_arch_reg_index,
   input  logic [ADDR_WIDTH-1:0]                enq_pc,
   input  logic [PHY_REG_ID_WIDTH-1:0]          enq_rs1_idx,
   input  logic [PHY_REG_ID_WIDTH-1:0]          enq_rs2_idx,
   input  logic                                 enq_rs1_rdy,
   input  logic                                 enq_rs2_rdy,
   input  logic [REG_WIDTH-1:0]                 enq_rs1_val,
   input  logic [REG_WIDTH-1:0]                 enq_rs2_val,
   input  logic [WB_PORTS-1:0]                  wb_vld,
   input  logic [WB_PORTS*PHY_REG_ID_WIDTH-1:0] wb_idx,
   input  logic [WB_PORTS*REG_WIDTH-1:0]        wb_val,
   input  logic                                 cancel_en,
   output logic                                 issue_vld,
   input  logic                                 issue_rdy,
   output logic [INST_WIDTH-1:0]                issue_inst_pld,
   output logic [INST_IDX_WIDTH-1:0]            issue_inst_idx,
   output logic [PHY_REG_ID_WIDTH-1:0]          issue_rd_idx,
   output logic                                 issue_rd_en,
   output logic                                 issue_c_ext,
   output logic [4:0]                           issue_arch_reg_index,
   output logic [ADDR_WIDTH-1:0]                issue_pc,
   output logic [REG_WIDTH-1:0]                 issue_rs1_val,
   output logic [REG_WIDTH-1:0]                 issue_rs2_val,
   output logic [$clog2(DEPTH):0]               iq_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [IDX_W:0]    count;
   logic [DEPTH-1:0]  valid;
   mext_iq_entry_pkg  entries [DEPTH];
   mext_iq_entry_pkg  enq_entry;

   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic              full, head_valid, enq_fire, deq_fire;
   logic              enq_rs1_rdy_c, enq_rs2_rdy_c;
   logic [REG_WIDTH-1:0] enq_rs1_val_c, enq_rs2_val_c;

   logic                 wk_rs1_rdy [DEPTH];
   logic                 wk_rs2_rdy [DEPTH];
   logic [REG_WIDTH-1:0] wk_rs1_val [DEPTH];
   logic [REG_WIDTH-1:0] wk_rs2_val [DEPTH];

   assign wr_idx     = wr_ptr[IDX_W-1:0];
   assign rd_idx     = rd_ptr[IDX_W-1:0];
   assign full       = (count == (IDX_W+1)'(DEPTH));
   assign enq_rdy    = !full;
   assign head_valid = valid[rd_idx];
   assign issue_vld  = head_valid & entries[rd_idx].rs1.rdy & entries[rd_idx].rs2.rdy & !cancel_en;
   assign enq_fire   = enq_vld & enq_rdy & !cancel_en;
   assign deq_fire   = issue_vld & issue_rdy;
   assign iq_count   = count;

   toy_mext_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_enq_rs1 (
      .cur_rdy(enq_rs1_rdy), .cur_idx(enq_rs1_idx), .cur_val(enq_rs1_val),
      .wb_vld(wb_vld), .wb_idx(wb_idx), .wb_val(wb_val),
      .nxt_rdy(enq_rs1_rdy_c), .nxt_val(enq_rs1_val_c)
   );

   toy_mext_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_enq_rs2 (
      .cur_rdy(enq_rs2_rdy), .cur_idx(enq_rs2_idx), .cur_val(enq_rs2_val),
      .wb_vld(wb_vld), .wb_idx(wb_idx), .wb_val(wb_val),
      .nxt_rdy(enq_rs2_rdy_c), .nxt_val(enq_rs2_val_c)
   );

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      toy_mext_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_rs1 (
         .cur_rdy(entries[i].rs1.rdy), .cur_idx(entries[i].rs1.idx), .cur_val(entries[i].rs1.val),
         .wb_vld(wb_vld), .wb_idx(wb_idx), .wb_val(wb_val),
         .nxt_rdy(wk_rs1_rdy[i]), .nxt_val(wk_rs1_val[i])
      );
      toy_mext_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_rs2 (
         .cur_rdy(entries[i].rs2.rdy), .cur_idx(entries[i].rs2.idx), .cur_val(entries[i].rs2.val),
         .wb_vld(wb_vld), .wb_idx(wb_idx), .wb_val(wb_val),
         .nxt_rdy(wk_rs2_rdy[i]), .nxt_val(wk_rs2_val[i])
      );
   end

   always_comb begin
      enq_entry                = '0;
      enq_entry.inst_pld       = enq_inst_pld;
      enq_entry.inst_idx       = enq_inst_idx;
      enq_entry.rd_idx         = enq_rd_idx;
      enq_entry.rd_en          = enq_rd_en;
      enq_entry.c_ext          = enq_c_ext;
      enq_entry.arch_reg_index = enq_arch_reg_index;
      enq_entry.pc             = enq_pc;
      enq_entry.rs1.idx        = enq_rs1_idx;
      enq_entry.rs1.rdy        = enq_rs1_rdy_c;
      enq_entry.rs1.val        = enq_rs1_val_c;
      enq_entry.rs2.idx        = enq_rs2_idx;
      enq_entry.rs2.rdy        = enq_rs2_rdy_c;
      enq_entry.rs2.val        = enq_rs2_val_c;
   end

   // Cancel takes precedence over everything, including wakeups landing that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else if (cancel_en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
         if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
         if (enq_fire && !deq_fire)      count <= count + 1'b1;
         else if (deq_fire && !enq_fire) count <= count - 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
               entries[i].rs1.rdy <= wk_rs1_rdy[i];
               entries[i].rs1.val <= wk_rs1_val[i];
               entries[i].rs2.rdy <= wk_rs2_rdy[i];
               entries[i].rs2.val <= wk_rs2_val[i];
            end
            if (deq_fire && (rd_idx == IDX_W'(i))) valid[i] <= 1'b0;
            if (enq_fire && (wr_idx == IDX_W'(i))) begin
               entries[i] <= enq_entry;
               valid[i]   <= 1'b1;
            end
         end
      end
   end

   // Payload reads as zero whenever the head slot is empty, e.g. after reset or cancel.
   always_comb begin
      issue_inst_pld       = '0;
      issue_inst_idx       = '0;
      issue_rd_idx         = '0;
      issue_rd_en          = 1'b0;
      issue_c_ext          = 1'b0;
      issue_arch_reg_index = '0;
      issue_pc             = '0;
      issue_rs1_val        = '0;
      issue_rs2_val        = '0;
      if (head_valid) begin
         issue_inst_pld       = entries[rd_idx].inst_pld;
         issue_inst_idx       = entries[rd_idx].inst_idx;
         issue_rd_idx         = entries[rd_idx].rd_idx;
         issue_rd_en          = entries[rd_idx].rd_en;
         issue_c_ext          = entries[rd_idx].c_ext;
         issue_arch_reg_index = entries[rd_idx].arch_reg_index;
         issue_pc             = entries[rd_idx].pc;
         issue_rs1_val        = entries[rd_idx].rs1.val;
         issue_rs2_val        = entries[rd_idx].rs2.val;
      end
   end

endmodule

// File: tb/tb_toy_mext_iq.sv
// Directed bench for toy_mext_iq: a per-cycle vector table for the basic
// issue/wakeup/bypass/ordering cases plus sequences for fill, wrap, cancel and reset.
module tb_toy_mext_iq;
   import toy_mext_iq_pkg::*;

   localparam int WBP = 2;

   logic                             clk = 1'b0;
   logic                             rst;
   logic                             enq_vld, enq_rdy;
   logic [INST_WIDTH-1:0]            enq_inst_pld;
   logic [INST_IDX_WIDTH-1:0]        enq_inst_idx;
   logic [PHY_REG_ID_WIDTH-1:0]      enq_rd_idx;
   logic                             enq_rd_en, enq_c_ext;
   logic [4:0]                       enq_arch_reg_index;
   logic [ADDR_WIDTH-1:0]            enq_pc;
   logic [PHY_REG_ID_WIDTH-1:0]      enq_rs1_idx, enq_rs2_idx;
   logic                             enq_rs1_rdy, enq_rs2_rdy;
   logic [REG_WIDTH-1:0]             enq_rs1_val, enq_rs2_val;
   logic [WBP-1:0]                   wb_vld;
   logic [WBP*PHY_REG_ID_WIDTH-1:0]  wb_idx;
   logic [WBP*REG_WIDTH-1:0]         wb_val;
   logic                             cancel_en;
   logic                             issue_vld, issue_rdy;
   logic [INST_WIDTH-1:0]            issue_inst_pld;
   logic [INST_IDX_WIDTH-1:0]        issue_inst_idx;
   logic [PHY_REG_ID_WIDTH-1:0]      issue_rd_idx;
   logic                             issue_rd_en, issue_c_ext;
   logic [4:0]                       issue_arch_reg_index;
   logic [ADDR_WIDTH-1:0]            issue_pc;
   logic [REG_WIDTH-1:0]             issue_rs1_val, issue_rs2_val;
   logic [2:0]                       iq_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        enq;
      int          inst;
      logic [6:0]  r1i;
      logic        r1r;
      logic [63:0] r1v;
      logic        r2r;
      logic [63:0] r2v;
      logic [1:0]  wbv;
      logic [6:0]  wi0;
      logic [63:0] wv0;
      logic [6:0]  wi1;
      logic [63:0] wv1;
      logic        irdy;
      logic        xv;
      int          xc;
      logic [63:0] x1;
      logic [63:0] x2;
      int          xi;
   } vec_t;

   vec_t vecs [19];
   int   q [$];

   toy_mext_iq #(.DEPTH(4), .WB_PORTS(WBP)) dut (
      .clk(clk), .rst(rst),
      .enq_vld(enq_vld), .enq_rdy(enq_rdy),
      .enq_inst_pld(enq_inst_pld), .enq_inst_idx(enq_inst_idx),
      .enq_rd_idx(enq_rd_idx), .enq_rd_en(enq_rd_en), .enq_c_ext(enq_c_ext),
      .enq_arch_reg_index(enq_arch_reg_index), .enq_pc(enq_pc),
      .enq_rs1_idx(enq_rs1_idx), .enq_rs2_idx(enq_rs2_idx),
      .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
      .enq_rs1_val(enq_rs1_val), .enq_rs2_val(enq_rs2_val),
      .wb_vld(wb_vld), .wb_idx(wb_idx), .wb_val(wb_val),
      .cancel_en(cancel_en),
      .issue_vld(issue_vld), .issue_rdy(issue_rdy),
      .issue_inst_pld(issue_inst_pld), .issue_inst_idx(issue_inst_idx),
      .issue_rd_idx(issue_rd_idx), .issue_rd_en(issue_rd_en), .issue_c_ext(issue_c_ext),
      .issue_arch_reg_index(issue_arch_reg_index), .issue_pc(issue_pc),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .iq_count(iq_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic enq, input int inst, input logic [6:0] r1i,
                               input logic r1r, input logic [63:0] r1v,
                               input logic r2r, input logic [63:0] r2v,
                               input logic [1:0] wbv, input logic [6:0] wi0, input logic [63:0] wv0,
                               input logic [6:0] wi1, input logic [63:0] wv1, input logic irdy,
                               input logic xv, input int xc, input logic [63:0] x1,
                               input logic [63:0] x2, input int xi);
      vec_t v;
      v.enq = enq; v.inst = inst; v.r1i = r1i; v.r1r = r1r; v.r1v = r1v;
      v.r2r = r2r; v.r2v = r2v; v.wbv = wbv; v.wi0 = wi0; v.wv0 = wv0;
      v.wi1 = wi1; v.wv1 = wv1; v.irdy = irdy;
      v.xv = xv; v.xc = xc; v.x1 = x1; v.x2 = x2; v.xi = xi;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      enq_vld = 1'b0; enq_inst_pld = '0; enq_inst_idx = '0; enq_rd_idx = '0;
      enq_rd_en = 1'b0; enq_c_ext = 1'b0; enq_arch_reg_index = '0; enq_pc = '0;
      enq_rs1_idx = '0; enq_rs2_idx = '0; enq_rs1_rdy = 1'b0; enq_rs2_rdy = 1'b0;
      enq_rs1_val = '0; enq_rs2_val = '0;
      wb_vld = '0; wb_idx = '0; wb_val = '0;
      cancel_en = 1'b0; issue_rdy = 1'b0;
   endtask

   task automatic enqSet(input int inst, input logic r1r, input logic [63:0] r1v,
                         input logic [6:0] r1i, input logic r2r, input logic [63:0] r2v);
      enq_vld            = 1'b1;
      enq_inst_idx       = INST_IDX_WIDTH'(inst);
      enq_inst_pld       = 32'h0200_0033 | 32'(inst);
      enq_rd_idx         = 7'(inst);
      enq_rd_en          = 1'b1;
      enq_arch_reg_index = 5'(inst);
      enq_pc             = 32'(inst * 4);
      enq_rs1_idx        = r1i;
      enq_rs1_rdy        = r1r;
      enq_rs1_val        = r1v;
      enq_rs2_rdy        = r2r;
      enq_rs2_val        = r2v;
   endtask

   task automatic applyStimulus(input vec_t v);
      idleInputs();
      if (v.enq) enqSet(v.inst, v.r1r, v.r1v, v.r1i, v.r2r, v.r2v);
      wb_vld    = v.wbv;
      wb_idx    = {v.wi1, v.wi0};
      wb_val    = {v.wv1, v.wv0};
      issue_rdy = v.irdy;
   endtask

   task automatic checkHead(input string tag, input int inst, input int cnt);
      checkOutput({tag, " issue_vld"}, 64'(issue_vld), 64'd1);
      checkOutput({tag, " inst_idx"}, 64'(issue_inst_idx), 64'(inst));
      checkOutput({tag, " rs1_val"}, issue_rs1_val, 64'(inst));
      checkOutput({tag, " iq_count"}, 64'(iq_count), 64'(cnt));
   endtask

   initial begin
      // enq inst r1i r1r r1v r2r r2v | wbv wi0 wv0 wi1 wv1 | irdy | xv xc x1 x2 xi
      vecs[0]  = mk(1, 1, 0, 1, 7, 1, 3,        2'b00, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 1, 1, 7, 3, 1);
      vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 2, 12, 0, 0, 1, 5,       2'b00, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 0, 1, 0, 0, 0);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 0, 1, 0, 0, 0);
      vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0,        2'b10, 0, 0, 12, 'h55,    1, 0, 1, 0, 0, 0);
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 1, 1, 'h55, 5, 2);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0);
      vecs[9]  = mk(1, 3, 9, 0, 0, 1, 1,        2'b01, 9, 'h1234, 0, 0,   1, 0, 0, 0, 0, 0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 1, 1, 'h1234, 1, 3);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0);
      vecs[12] = mk(1, 4, 20, 0, 0, 1, 2,       2'b00, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0);
      vecs[13] = mk(1, 5, 0, 1, 10, 1, 11,      2'b00, 0, 0, 0, 0,        1, 0, 1, 0, 0, 0);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 0, 2, 0, 0, 0);
      vecs[15] = mk(0, 0, 0, 0, 0, 0, 0,        2'b11, 20, 'h99, 20, 'h77, 1, 0, 2, 0, 0, 0);
      vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 1, 2, 'h99, 2, 4);
      vecs[17] = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 1, 1, 10, 11, 5);
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0);

      rst = 1'b1;
      idleInputs();
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset issue_vld", 64'(issue_vld), 64'd0);
      checkOutput("reset iq_count", 64'(iq_count), 64'd0);
      checkOutput("reset enq_rdy", 64'(enq_rdy), 64'd1);
      checkOutput("reset rs1_val", issue_rs1_val, 64'd0);
      checkOutput("reset inst_idx", 64'(issue_inst_idx), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d issue_vld", i), 64'(issue_vld), 64'(vecs[i].xv));
         checkOutput($sformatf("v%0d iq_count", i), 64'(iq_count), 64'(vecs[i].xc));
         checkOutput($sformatf("v%0d enq_rdy", i), 64'(enq_rdy), 64'(vecs[i].xc < 4));
         if (vecs[i].xv) begin
            checkOutput($sformatf("v%0d rs1_val", i), issue_rs1_val, vecs[i].x1);
            checkOutput($sformatf("v%0d rs2_val", i), issue_rs2_val, vecs[i].x2);
            checkOutput($sformatf("v%0d inst_idx", i), 64'(issue_inst_idx), 64'(vecs[i].xi));
         end
      end

      // Fill to full with issue blocked; the fifth offer must be refused.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         idleInputs();
         enqSet(10 + k, 1'b1, 64'(10 + k), 7'd0, 1'b1, 64'd0);
         #1;
         checkOutput($sformatf("fill%0d enq_rdy", k), 64'(enq_rdy), 64'(k < 4));
         checkOutput($sformatf("fill%0d iq_count", k), 64'(iq_count), 64'((k < 4) ? k : 4));
         if (k < 4) q.push_back(10 + k);
      end
      @(negedge clk);
      idleInputs();
      enqSet(99, 1'b1, 64'd99, 7'd0, 1'b1, 64'd0);
      issue_rdy = 1'b1;
      #1;
      checkOutput("full enq_rdy with deq", 64'(enq_rdy), 64'd0);
      checkHead("full head", q[0], 4);
      void'(q.pop_front());

      // Paired enqueue/dequeue around the ring, order tracked against a queue.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         idleInputs();
         enqSet(20 + k, 1'b1, 64'(20 + k), 7'd0, 1'b1, 64'd0);
         issue_rdy = 1'b1;
         #1;
         checkHead($sformatf("wrap%0d", k), q[0], 3);
         checkOutput($sformatf("wrap%0d enq_rdy", k), 64'(enq_rdy), 64'd1);
         void'(q.pop_front());
         q.push_back(20 + k);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         idleInputs();
         issue_rdy = 1'b1;
         #1;
         checkHead($sformatf("drain%0d", k), q[0], 3 - k);
         void'(q.pop_front());
      end
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("drained iq_count", 64'(iq_count), 64'd0);
      checkOutput("drained issue_vld", 64'(issue_vld), 64'd0);

      // Cancel with three waiting entries, a colliding enqueue and a matching wakeup.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         idleInputs();
         enqSet(30 + k, 1'b0, 64'd0, 7'd30, 1'b1, 64'd0);
         issue_rdy = 1'b1;
      end
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("precancel iq_count", 64'(iq_count), 64'd3);
      checkOutput("precancel issue_vld", 64'(issue_vld), 64'd0);
      @(negedge clk);
      idleInputs();
      enqSet(40, 1'b1, 64'd40, 7'd0, 1'b1, 64'd0);
      cancel_en = 1'b1;
      issue_rdy = 1'b1;
      wb_vld    = 2'b01;
      wb_idx    = {7'd0, 7'd30};
      wb_val    = {64'd0, 64'hABCD};
      #1;
      checkOutput("cancel cycle issue_vld", 64'(issue_vld), 64'd0);
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("postcancel iq_count", 64'(iq_count), 64'd0);
      checkOutput("postcancel issue_vld", 64'(issue_vld), 64'd0);
      checkOutput("postcancel enq_rdy", 64'(enq_rdy), 64'd1);
      checkOutput("postcancel inst_idx", 64'(issue_inst_idx), 64'd0);
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("dropped enq iq_count", 64'(iq_count), 64'd0);
      checkOutput("dropped enq issue_vld", 64'(issue_vld), 64'd0);

      // A ready head must not issue while cancel is asserted.
      @(negedge clk);
      idleInputs();
      enqSet(50, 1'b1, 64'd50, 7'd0, 1'b1, 64'd0);
      @(negedge clk);
      idleInputs();
      cancel_en = 1'b1;
      issue_rdy = 1'b1;
      #1;
      checkOutput("cancel ready head issue_vld", 64'(issue_vld), 64'd0);
      checkOutput("cancel ready head iq_count", 64'(iq_count), 64'd1);
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("cancel2 iq_count", 64'(iq_count), 64'd0);

      // Queue is usable again, then reset arrives asynchronously mid-traffic.
      @(negedge clk);
      idleInputs();
      enqSet(60, 1'b1, 64'd60, 7'd0, 1'b1, 64'd0);
      @(negedge clk);
      idleInputs();
      enqSet(61, 1'b1, 64'd61, 7'd0, 1'b1, 64'd0);
      #1;
      checkHead("after cancel", 60, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst iq_count", 64'(iq_count), 64'd0);
      checkOutput("async rst issue_vld", 64'(issue_vld), 64'd0);
      checkOutput("async rst enq_rdy", 64'(enq_rdy), 64'd1);
      checkOutput("async rst rs1_val", issue_rs1_val, 64'd0);
      @(negedge clk);
      idleInputs();
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("post rst iq_count", 64'(iq_count), 64'd0);
      checkOutput("post rst issue_vld", 64'(issue_vld), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
